// File: rtl/sha256_w_sched_ctrl_if.sv
// Handshake bundle for sha256_w_sched_ctrl: block input side and word output side.
// Optional in_pad exists only when SHA256_PAD_SECOND_EN is defined.
interface sha256_w_sched_ctrl_if #(
  parameter int unsigned IDX_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [511:0]     block_in;
  logic             abort;
  logic             w_valid;
  logic             w_ready;
  logic [31:0]      w_data;
  logic [IDX_W-1:0] w_idx;
  logic             w_last;
  logic             busy;
`ifdef SHA256_PAD_SECOND_EN
  logic             in_pad;
`endif

  // Controller view
  modport slave (
    input  in_valid, block_in, abort, w_ready,
`ifdef SHA256_PAD_SECOND_EN
    input  in_pad,
`endif
    output in_ready, w_valid, w_data, w_idx, w_last, busy
  );

  // Source / consumer view
  modport master (
    output in_valid, block_in, abort, w_ready,
`ifdef SHA256_PAD_SECOND_EN
    output in_pad,
`endif
    input  in_ready, w_valid, w_data, w_idx, w_last, busy
  );
endinterface

// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message-schedule sequencer: accepts a 512-bit block, streams
// W0..W(ROUNDS-1) with on-the-fly expansion over a 16-word sliding window.
// Optional macro SHA256_PAD_SECOND_EN: in_pad=1 loads a 256-bit digest with
// fixed second-hash padding (W8=0x80000000, W15=0x00000100).
module sha256_w_sched_ctrl #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic CLK,
  input  logic RST,
  sha256_w_sched_ctrl_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_win [16];
  logic [31:0]      w_load [16];
  logic [IDX_W-1:0] r_t;

  logic        w_run;
  logic        w_last;
  logic        w_xfer;
  logic        w_in_ready;
  logic        w_accept;
  logic [31:0] w_new;

  function automatic logic [31:0] f_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign w_run      = (r_state == ST_RUN);
  assign w_last     = w_run && (r_t == LAST_IDX);
  assign w_xfer     = w_run && bus.w_ready;
  // abort suppresses the chained accept on the last transfer
  assign w_in_ready = !w_run || (w_last && bus.w_ready && !bus.abort);
  assign w_accept   = bus.in_valid && w_in_ready && !bus.abort;
  assign w_new      = f_s1(r_win[14]) + r_win[9] + f_s0(r_win[1]) + r_win[0];

  assign bus.in_ready = w_in_ready;
  assign bus.w_valid  = w_run;
  assign bus.busy     = w_run;
  assign bus.w_last   = w_last;
  assign bus.w_data   = r_win[0];
  assign bus.w_idx    = r_t;

  // Window load value: verbatim block words, or digest plus fixed padding
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      w_load[i] = bus.block_in[511 - 32*i -: 32];
    end
`ifdef SHA256_PAD_SECOND_EN
    if (bus.in_pad) begin
      for (int unsigned i = 8; i < 16; i++) begin
        w_load[i] = '0;
      end
      w_load[8]  = 32'h8000_0000;
      w_load[15] = 32'h0000_0100;
    end
`endif
  end

  // Next-state: abort beats accept beats end-of-block
  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
    end else if (w_accept) begin
      w_state_nxt = ST_RUN;
    end else if (w_xfer && w_last) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Window and round index: load on accept, slide and expand on each transfer
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_t <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        r_win[i] <= '0;
      end
    end else if (bus.abort) begin
      r_t <= '0;
    end else if (w_accept) begin
      r_t <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        r_win[i] <= w_load[i];
      end
    end else if (w_xfer) begin
      r_t <= w_last ? '0 : r_t + IDX_W'(1);
      for (int unsigned i = 0; i < 15; i++) begin
        r_win[i] <= r_win[i+1];
      end
      r_win[15] <= w_new;
    end
  end

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
// Self-checking bench for sha256_w_sched_ctrl with a whole-schedule reference model.
module tb_sha256_w_sched_ctrl;

  localparam int ROUNDS = 64;
  localparam int IDX_W  = 6;

  typedef logic [31:0] wblk_t  [16];
  typedef logic [31:0] sched_t [ROUNDS];

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] cap [ROUNDS];

  always #5 CLK = ~CLK;

  sha256_w_sched_ctrl_if #(.IDX_W(IDX_W)) bus ();

  sha256_w_sched_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Reference model: full schedule from the textbook recurrence
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void expand(input wblk_t b, output sched_t s);
    for (int t = 0; t < ROUNDS; t++) begin
      if (t < 16) s[t] = b[t];
      else s[t] = (rotr(s[t-2], 17) ^ rotr(s[t-2], 19) ^ (s[t-2] >> 10))
                  + s[t-7]
                  + (rotr(s[t-15], 7) ^ rotr(s[t-15], 18) ^ (s[t-15] >> 3))
                  + s[t-16];
    end
  endfunction

  function automatic logic [511:0] pack(input wblk_t b);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[511 - 32*i -: 32] = b[i];
    return v;
  endfunction

  function automatic void rand_blk(output wblk_t b);
    for (int i = 0; i < 16; i++) b[i] = $urandom;
  endfunction

  // Present a block from IDLE and wait (bounded) for acceptance
  task automatic present(input wblk_t b);
    int n = 0;
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.block_in = pack(b);
    #1;
    while (!bus.in_ready && n < 100) begin
      @(negedge CLK);
      #1;
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready=%b required 1", bus.in_ready);
    end
    @(posedge CLK);
    #1 bus.in_valid = 1'b0;
  endtask

  // Consume a whole block; stall_pct random stalls, 5-cycle hold at hold_at
  task automatic consume(input sched_t e, input int stall_pct, input int hold_at);
    int k = 0;
    int cyc = 0;
    int hold = 0;
    logic exp_rdy;
    while (k < ROUNDS && cyc < 5000) begin
      @(negedge CLK);
      cyc++;
      if (k == hold_at && hold < 5) begin
        bus.w_ready = 1'b0;
        hold++;
      end else begin
        bus.w_ready = ($urandom_range(99) >= stall_pct);
      end
      #1;
      exp_rdy = (k == ROUNDS - 1) && bus.w_ready;
      checks++;
      if (bus.w_valid !== 1'b1 || bus.busy !== 1'b1 || bus.w_data !== e[k] ||
          bus.w_idx !== IDX_W'(k) || bus.w_last !== (k == ROUNDS - 1) ||
          bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL word k=%0d got v=%b b=%b d=%h i=%0d l=%b r=%b required d=%h r=%b",
                 k, bus.w_valid, bus.busy, bus.w_data, bus.w_idx, bus.w_last,
                 bus.in_ready, e[k], exp_rdy);
      end
      cap[k] = bus.w_data;
      if (bus.w_ready) k++;
    end
    checks++;
    if (k != ROUNDS) begin
      errors++;
      $display("FAIL consume_timeout got %0d words required %0d", k, ROUNDS);
    end
  endtask

  // Consume words 0..stop-1 with w_ready high
  task automatic run_to(input sched_t e, input int stop);
    for (int k = 0; k < stop; k++) begin
      @(negedge CLK);
      bus.w_ready = 1'b1;
      #1;
      checks++;
      if (bus.w_valid !== 1'b1 || bus.w_data !== e[k] || bus.w_idx !== IDX_W'(k)) begin
        errors++;
        $display("FAIL run_to k=%0d got v=%b d=%h i=%0d required d=%h",
                 k, bus.w_valid, bus.w_data, bus.w_idx, e[k]);
      end
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge CLK);
    #1;
    checks++;
    if (bus.w_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.w_idx !== '0 || bus.w_last !== 1'b0) begin
      errors++;
      $display("FAIL %s got v=%b b=%b rdy=%b i=%0d l=%b required 0 0 1 0 0",
               name, bus.w_valid, bus.busy, bus.in_ready, bus.w_idx, bus.w_last);
    end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    bus.in_valid = 1'b0;
    bus.block_in = '0;
    bus.abort    = 1'b0;
    bus.w_ready  = 1'b0;
`ifdef SHA256_PAD_SECOND_EN
    bus.in_pad   = 1'b0;
`endif
    #12;
    checks++;
    if (bus.w_valid !== 1'b0 || bus.w_data !== 32'h0 || bus.w_idx !== '0 ||
        bus.w_last !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h i=%0d l=%b b=%b required all 0",
               bus.w_valid, bus.w_data, bus.w_idx, bus.w_last, bus.busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    check_idle("reset_release");
  endtask

  task automatic test_idle_ignore;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      bus.w_ready = 1'b1;
    end
    check_idle("idle_wready_ignored");
    bus.w_ready = 1'b0;
  endtask

  task automatic test_abc;
    wblk_t  b;
    sched_t e;
    for (int i = 0; i < 16; i++) b[i] = 32'h0;
    b[0]  = 32'h6162_6380;
    b[15] = 32'h0000_0018;
    expand(b, e);
    present(b);
    consume(e, 0, -1);
    checks++;
    if (cap[16] !== 32'h6162_6380 || cap[17] !== 32'h000F_0000 ||
        cap[18] !== 32'h7DA8_6405 || cap[63] !== 32'h12B1_EDEB) begin
      errors++;
      $display("FAIL abc_known got %h %h %h %h required 61626380 000f0000 7da86405 12b1edeb",
               cap[16], cap[17], cap[18], cap[63]);
    end
    check_idle("abc_busy_falls");
  endtask

  task automatic test_stall;
    wblk_t  b;
    sched_t e;
    for (int i = 0; i < 16; i++) b[i] = 32'h0;
    b[0]  = 32'h6162_6380;
    b[15] = 32'h0000_0018;
    expand(b, e);
    present(b);
    consume(e, 0, 20);
    check_idle("stall_end");
    rand_blk(b);
    expand(b, e);
    present(b);
    consume(e, 40, 7);
    check_idle("stall_rand_end");
  endtask

  task automatic test_back_to_back;
    wblk_t  a, b;
    sched_t ea, eb;
    rand_blk(a);
    rand_blk(b);
    expand(a, ea);
    expand(b, eb);
    present(a);
    bus.in_valid = 1'b1;
    bus.block_in = pack(b);
    consume(ea, 30, -1);
    @(posedge CLK);
    #1 bus.in_valid = 1'b0;
    consume(eb, 0, -1);
    check_idle("b2b_end");
  endtask

  task automatic test_abort;
    wblk_t  b, z;
    sched_t e, ez;
    rand_blk(b);
    expand(b, e);
    present(b);
    run_to(e, 30);
    @(negedge CLK);
    bus.w_ready  = 1'b1;
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.w_idx !== IDX_W'(30) || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_cycle got i=%0d rdy=%b required 30 0", bus.w_idx, bus.in_ready);
    end
    @(posedge CLK);
    #1;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("abort_next");
    // abort in IDLE also blocks an offered block
    @(negedge CLK);
    bus.abort    = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("abort_idle_no_accept");
    for (int i = 0; i < 16; i++) z[i] = 32'h0;
    expand(z, ez);
    present(z);
    consume(ez, 20, -1);
    check_idle("abort_zero_end");
  endtask

  task automatic test_rst_mid;
    wblk_t  b;
    sched_t e;
    rand_blk(b);
    expand(b, e);
    present(b);
    run_to(e, 40);
    @(negedge CLK);
    bus.w_ready = 1'b1;
    #1;
    checks++;
    if (bus.w_idx !== IDX_W'(40) || bus.w_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pos got i=%0d v=%b required 40 1", bus.w_idx, bus.w_valid);
    end
    #1 RST = 1'b0;
    #1;
    checks++;
    if (bus.w_valid !== 1'b0 || bus.w_data !== 32'h0 || bus.w_idx !== '0 ||
        bus.w_last !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got v=%b d=%h i=%0d l=%b b=%b required all 0",
               bus.w_valid, bus.w_data, bus.w_idx, bus.w_last, bus.busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    check_idle("rst_release");
    check_idle("rst_no_partial");
  endtask

  task automatic test_random;
    wblk_t  b;
    sched_t e;
    for (int n = 0; n < 3; n++) begin
      rand_blk(b);
      expand(b, e);
      present(b);
      consume(e, 35, -1);
      check_idle("random_end");
    end
  endtask

`ifdef SHA256_PAD_SECOND_EN
  task automatic test_pad;
    wblk_t  raw, exp_b;
    sched_t e;
    rand_blk(raw);
    for (int i = 0; i < 8; i++) raw[i] = 32'h1111_1111 * (i + 1);
    for (int i = 0; i < 16; i++) exp_b[i] = (i < 8) ? raw[i] : 32'h0;
    exp_b[8]  = 32'h8000_0000;
    exp_b[15] = 32'h0000_0100;
    expand(exp_b, e);
    bus.in_pad = 1'b1;
    present(raw);
    bus.in_pad = 1'b0;
    consume(e, 25, -1);
    check_idle("pad_end");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_abc();
    test_stall();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_random();
`ifdef SHA256_PAD_SECOND_EN
    test_pad();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
